// File: rtl/cnn_param_pkg.sv
// cnn_param_pkg: shared constants for the CNN parameter loader.
// Holds the FSM state encoding, the segment base-address table and the default load size.
package cnn_param_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int unsigned CNN_TOTAL_BYTES = 529;
    localparam int unsigned CNN_NUM_SEG     = 24;

    // First ROM byte of each destination segment, ascending; the last segment runs to the end of the image.
    localparam int unsigned SEG_BASE [CNN_NUM_SEG] = '{
          0,   9,  31,  53,  75,  97, 119, 141,
        163, 185, 207, 229, 251, 273, 295, 317,
        339, 361, 383, 405, 427, 449, 471, 493
    };

endpackage

// File: rtl/param_loader_seg_decode.sv
// param_seg_decode: maps a flat ROM byte address to (segment, offset-within-segment).
// Purely combinational; uses the ascending base table from cnn_param_pkg.
module param_seg_decode
    import cnn_param_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned NUM_SEG = CNN_NUM_SEG
) (
    input  logic [ADDR_W-1:0]          i_addr,
    output logic [$clog2(NUM_SEG)-1:0] o_seg,
    output logic [ADDR_W-1:0]          o_off
);

    localparam int unsigned SEG_W = $clog2(NUM_SEG);
    localparam int unsigned N_TAB = (NUM_SEG < CNN_NUM_SEG) ? NUM_SEG : CNN_NUM_SEG;

    // Bases are ascending, so the last base not above the address wins.
    always_comb begin
        o_seg = '0;
        o_off = i_addr;
        for (int unsigned k = 1; k < N_TAB; k++) begin
            if (i_addr >= ADDR_W'(SEG_BASE[k])) begin
                o_seg = SEG_W'(k);
                o_off = i_addr - ADDR_W'(SEG_BASE[k]);
            end
        end
    end

endmodule

// File: rtl/param_loader.sv
// param_loader: streams TOTAL_BYTES from a fixed-latency ROM onto a segmented write bus.
// Define PARAM_LOADER_CHECKSUM_EN to add EXPECTED_SUM and a mod-256 checksum flag (sum_err).
module param_loader
    import cnn_param_pkg::*;
#(
    parameter int unsigned TOTAL_BYTES = CNN_TOTAL_BYTES,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned ROM_LATENCY = 2,
    parameter int unsigned NUM_SEG     = CNN_NUM_SEG,
    parameter bit          AUTO_START  = 1'b1
`ifdef PARAM_LOADER_CHECKSUM_EN
    ,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       rom_en,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [7:0]                 rom_dout,
    output logic                       wr_valid,
    output logic [$clog2(NUM_SEG)-1:0] wr_seg,
    output logic [ADDR_W-1:0]          wr_off,
    output logic [7:0]                 wr_data,
`ifdef PARAM_LOADER_CHECKSUM_EN
    output logic                       sum_err,
`endif
    output logic                       busy,
    output logic                       done
);

    state_t                       r_state;
    logic                         r_rom_en;
    logic [ADDR_W-1:0]            r_rom_addr;
    logic [ROM_LATENCY-1:0]       r_pv;
    logic [ADDR_W-1:0]            r_pa [ROM_LATENCY];
    logic                         r_wr_valid;
    logic [$clog2(NUM_SEG)-1:0]   r_wr_seg;
    logic [ADDR_W-1:0]            r_wr_off;
    logic [7:0]                   r_wr_data;

    logic                         w_pipe_busy;
    logic                         w_last_addr;
    logic                         w_start_load;
    logic [$clog2(NUM_SEG)-1:0]   w_seg;
    logic [ADDR_W-1:0]            w_off;

    assign w_pipe_busy  = |r_pv;
    assign w_last_addr  = (r_rom_addr == ADDR_W'(TOTAL_BYTES - 1));
    assign w_start_load = ((r_state == ST_IDLE) && (start || AUTO_START))
                       || ((r_state == ST_DONE) && start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
        end else if (w_start_load) begin
            r_state    <= ST_FETCH;
            r_rom_en   <= 1'b1;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_last_addr) begin
                        r_rom_en <= 1'b0;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: if (!w_pipe_busy) r_state <= ST_DONE;
                default: ;
            endcase
        end
    end

    // Stage k holds the read issued k+1 clocks ago; the last stage lines up with rom_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++) r_pa[i] <= '0;
        end else begin
            r_pv[0] <= r_rom_en;
            r_pa[0] <= r_rom_addr;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    param_seg_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_SEG (NUM_SEG)
    ) u_seg_decode (
        .i_addr (r_pa[ROM_LATENCY-1]),
        .o_seg  (w_seg),
        .o_off  (w_off)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_seg   <= '0;
            r_wr_off   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= r_pv[ROM_LATENCY-1];
            if (r_pv[ROM_LATENCY-1]) begin
                r_wr_seg  <= w_seg;
                r_wr_off  <= w_off;
                r_wr_data <= rom_dout;
            end
        end
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_sum_err;
    logic [7:0] w_sum_next;

    // The final byte is still on the wr bus on the DONE-entry clock, so judge the sum including it.
    assign w_sum_next = r_sum + (r_wr_valid ? r_wr_data : 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum     <= '0;
            r_sum_err <= 1'b0;
        end else if (w_start_load) begin
            r_sum     <= '0;
            r_sum_err <= 1'b0;
        end else begin
            r_sum <= w_sum_next;
            if ((r_state == ST_DRAIN) && !w_pipe_busy)
                r_sum_err <= (w_sum_next != EXPECTED_SUM);
        end
    end

    assign sum_err = r_sum_err;
`endif

    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign wr_valid = r_wr_valid;
    assign wr_seg   = r_wr_seg;
    assign wr_off   = r_wr_off;
    assign wr_data  = r_wr_data;
    assign busy     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader: scoreboard bench for param_loader (latency 2 / latency 4 / single-byte builds,
// plus checksum builds when PARAM_LOADER_CHECKSUM_EN is defined).
module tb_param_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [22:0] word;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_pass = 0;
    int unsigned n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Segment layout: seg0 = bytes 0..8, seg1..22 = 22 bytes each from 9, seg23 = 493..528.
    function automatic logic [22:0] exp_word(input int unsigned a, input logic [7:0] d);
        int unsigned s, b;
        s = (a < 9) ? 0 : ((a - 9) / 22 + 1);
        if (s > 23) s = 23;
        b = (s == 0) ? 0 : 9 + 22 * (s - 1);
        return {5'(s), 10'(a - b), d};
    endfunction

    function automatic logic [7:0] rom_a(input int unsigned a);
        return 8'(a * 7 + 3);
    endfunction

    // ---------------- DUT A: defaults (latency 2, auto start) ----------------
    logic rst_a = 1'b1, start_a = 1'b0;
    logic a_rom_en, a_wr_valid, a_busy, a_done;
    logic [9:0] a_rom_addr, a_wr_off;
    logic [7:0] a_rom_dout, a_wr_data;
    logic [4:0] a_wr_seg;
    logic [9:0] ra_q0, ra_q1;
    always @(posedge clk) begin
        ra_q0 <= a_rom_addr;
        ra_q1 <= ra_q0;
    end
    assign a_rom_dout = rom_a(32'(ra_q1));
`ifdef PARAM_LOADER_CHECKSUM_EN
    logic a_sum_err, b_sum_err, c_sum_err;
`endif

    param_loader u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a),
        .rom_en(a_rom_en), .rom_addr(a_rom_addr), .rom_dout(a_rom_dout),
        .wr_valid(a_wr_valid), .wr_seg(a_wr_seg), .wr_off(a_wr_off), .wr_data(a_wr_data),
`ifdef PARAM_LOADER_CHECKSUM_EN
        .sum_err(a_sum_err),
`endif
        .busy(a_busy), .done(a_done)
    );

    // ---------------- DUT B: latency 4, ROM = address[7:0] ----------------
    logic rst_b = 1'b1, start_b = 1'b0;
    logic b_rom_en, b_wr_valid, b_busy, b_done;
    logic [9:0] b_rom_addr, b_wr_off;
    logic [7:0] b_rom_dout, b_wr_data;
    logic [4:0] b_wr_seg;
    logic [9:0] rb_q [4];
    always @(posedge clk) begin
        rb_q[0] <= b_rom_addr;
        for (int i = 1; i < 4; i++) rb_q[i] <= rb_q[i-1];
    end
    assign b_rom_dout = rb_q[3][7:0];

    param_loader #(.ROM_LATENCY(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b),
        .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_dout(b_rom_dout),
        .wr_valid(b_wr_valid), .wr_seg(b_wr_seg), .wr_off(b_wr_off), .wr_data(b_wr_data),
`ifdef PARAM_LOADER_CHECKSUM_EN
        .sum_err(b_sum_err),
`endif
        .busy(b_busy), .done(b_done)
    );

    // ---------------- DUT C: one byte, latency 1, manual start ----------------
    logic rst_c = 1'b1, start_c = 1'b0;
    logic c_rom_en, c_wr_valid, c_busy, c_done;
    logic [9:0] c_rom_addr, c_wr_off;
    logic [7:0] c_rom_dout, c_wr_data;
    logic [4:0] c_wr_seg;
    logic [9:0] rc_q;
    always @(posedge clk) rc_q <= c_rom_addr;
    assign c_rom_dout = rom_a(32'(rc_q));

    param_loader #(.TOTAL_BYTES(1), .ROM_LATENCY(1), .AUTO_START(1'b0)) u_dut_c (
        .clk(clk), .rst(rst_c), .start(start_c),
        .rom_en(c_rom_en), .rom_addr(c_rom_addr), .rom_dout(c_rom_dout),
        .wr_valid(c_wr_valid), .wr_seg(c_wr_seg), .wr_off(c_wr_off), .wr_data(c_wr_data),
`ifdef PARAM_LOADER_CHECKSUM_EN
        .sum_err(c_sum_err),
`endif
        .busy(c_busy), .done(c_done)
    );

`ifdef PARAM_LOADER_CHECKSUM_EN
    // ---------------- DUTs D/E: all-0x01 ROM, good and bad expected sums ----------------
    logic rst_de = 1'b1, start_de = 1'b0;
    logic d_rom_en, d_wr_valid, d_busy, d_done, d_sum_err;
    logic e_rom_en, e_wr_valid, e_busy, e_done, e_sum_err;
    logic [9:0] d_rom_addr, d_wr_off, e_rom_addr, e_wr_off;
    logic [7:0] d_wr_data, e_wr_data;
    logic [4:0] d_wr_seg, e_wr_seg;
    logic [7:0] de_rom_dout;
    assign de_rom_dout = 8'h01;

    param_loader #(.EXPECTED_SUM(8'h11)) u_dut_d (
        .clk(clk), .rst(rst_de), .start(start_de),
        .rom_en(d_rom_en), .rom_addr(d_rom_addr), .rom_dout(de_rom_dout),
        .wr_valid(d_wr_valid), .wr_seg(d_wr_seg), .wr_off(d_wr_off), .wr_data(d_wr_data),
        .sum_err(d_sum_err), .busy(d_busy), .done(d_done)
    );

    param_loader #(.EXPECTED_SUM(8'h10)) u_dut_e (
        .clk(clk), .rst(rst_de), .start(start_de),
        .rom_en(e_rom_en), .rom_addr(e_rom_addr), .rom_dout(de_rom_dout),
        .wr_valid(e_wr_valid), .wr_seg(e_wr_seg), .wr_off(e_wr_off), .wr_data(e_wr_data),
        .sum_err(e_sum_err), .busy(e_busy), .done(e_done)
    );
`endif

    // ---------------- scoreboards ----------------
    exp_t q_a[$], q_b[$], q_c[$];
    int unsigned a_wr_cnt = 0, b_wr_cnt = 0, c_wr_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        if (a_wr_valid === 1'b1) begin
            a_wr_cnt <= a_wr_cnt + 1;
            if (q_a.size() == 0) begin
                n_tot++;
                $display("FAIL a_unexpected_write: got seg %0d off %0d data 0x%0h expected no write",
                         a_wr_seg, a_wr_off, a_wr_data);
            end else begin
                e = q_a.pop_front();
                chk("a_wr", 32'({a_wr_seg, a_wr_off, a_wr_data}), 32'(e.word));
                if (e.addr == 9)   chk("a_byte9_seg_off",   32'({a_wr_seg, a_wr_off}), 32'({5'd1, 10'd0}));
                if (e.addr == 8)   chk("a_byte8_seg_off",   32'({a_wr_seg, a_wr_off}), 32'({5'd0, 10'd8}));
                if (e.addr == 493) chk("a_byte493_seg_off", 32'({a_wr_seg, a_wr_off}), 32'({5'd23, 10'd0}));
                if (e.addr == 528) chk("a_byte528_seg_off", 32'({a_wr_seg, a_wr_off}), 32'({5'd23, 10'd35}));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_wr_valid === 1'b1) begin
            b_wr_cnt <= b_wr_cnt + 1;
            if (q_b.size() == 0) begin
                n_tot++;
                $display("FAIL b_unexpected_write: got seg %0d off %0d data 0x%0h expected no write",
                         b_wr_seg, b_wr_off, b_wr_data);
            end else begin
                e = q_b.pop_front();
                chk("b_wr", 32'({b_wr_seg, b_wr_off, b_wr_data}), 32'(e.word));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (c_wr_valid === 1'b1) begin
            c_wr_cnt <= c_wr_cnt + 1;
            if (q_c.size() == 0) begin
                n_tot++;
                $display("FAIL c_unexpected_write: got seg %0d off %0d data 0x%0h expected no write",
                         c_wr_seg, c_wr_off, c_wr_data);
            end else begin
                e = q_c.pop_front();
                chk("c_wr", 32'({c_wr_seg, c_wr_off, c_wr_data}), 32'(e.word));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic a_zero_chk(input string tag);
        chk({tag, "_ctl"}, 32'({a_rom_en, a_wr_valid, a_busy, a_done}), 32'd0);
        chk({tag, "_addr_off"}, 32'({a_rom_addr, a_wr_off}), 32'd0);
        chk({tag, "_seg_data"}, 32'({a_wr_seg, a_wr_data}), 32'd0);
    endtask

    task automatic push_a();
        for (int i = 0; i < 529; i++) q_a.push_back({32'(i), exp_word(i, rom_a(i))});
    endtask

    task automatic wait_a_done();
        for (int i = 0; i < 1000; i++) begin
            if (a_done === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic a_load_end_chk(input string tag, input int unsigned c0, input int unsigned n0);
        chk({tag, "_latency"}, cyc - c0, 32'd532);
        chk({tag, "_writes"}, a_wr_cnt - n0, 32'd529);
        chk({tag, "_busy_low"}, 32'(a_busy), 32'd0);
        chk({tag, "_rom_hold"}, 32'({a_rom_en, a_rom_addr}), 32'({1'b0, 10'd528}));
    endtask

    task automatic test_a();
        int unsigned c0, n0;
        // load 1: auto start after reset release, stray start at clock 100
        push_a();
        n0 = a_wr_cnt;
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_autostart_busy", 32'(a_busy), 32'd1);
        c0 = cyc;
        repeat (99) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a_done();
        a_load_end_chk("a_load1", c0, n0);
        // load 2: start from DONE
        push_a();
        n0 = a_wr_cnt;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_done_falls", 32'(a_done), 32'd0);
        chk("a_restart_busy", 32'(a_busy), 32'd1);
        c0 = cyc;
        wait_a_done();
        a_load_end_chk("a_load2", c0, n0);
        // load 3: reset at clock 200, then a fresh automatic load
        push_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (199) @(negedge clk);
        #2 rst_a = 1'b1;
        #1 a_zero_chk("a_mid_reset");
        q_a.delete();
        repeat (3) @(negedge clk);
        push_a();
        n0 = a_wr_cnt;
        rst_a = 1'b0;
        @(negedge clk);
        chk("a_post_reset_busy", 32'(a_busy), 32'd1);
        c0 = cyc;
        wait_a_done();
        a_load_end_chk("a_load3", c0, n0);
    endtask

    task automatic test_b();
        int unsigned c0;
        for (int i = 0; i < 529; i++) q_b.push_back({32'(i), exp_word(i, 8'(i))});
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_autostart_busy", 32'(b_busy), 32'd1);
        c0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            if (b_done === 1'b1) break;
            @(negedge clk);
        end
        chk("b_latency", cyc - c0, 32'd534);
        chk("b_writes", b_wr_cnt, 32'd529);
    endtask

    task automatic test_c();
        int unsigned c0;
        rst_c = 1'b0;
        repeat (5) @(negedge clk);
        chk("c_no_autostart", 32'({c_busy, c_done, c_rom_en}), 32'd0);
        q_c.push_back({32'd0, exp_word(0, rom_a(0))});
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("c_start_busy", 32'(c_busy), 32'd1);
        c0 = cyc;
        for (int i = 0; i < 50; i++) begin
            if (c_done === 1'b1) break;
            @(negedge clk);
        end
        chk("c_latency", cyc - c0, 32'd3);
        chk("c_writes", c_wr_cnt, 32'd1);
        chk("c_rom_hold", 32'({c_rom_en, c_rom_addr}), 32'd0);
    endtask

`ifdef PARAM_LOADER_CHECKSUM_EN
    task automatic wait_de_done();
        for (int i = 0; i < 1000; i++) begin
            if (d_done === 1'b1 && e_done === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_sum();
        rst_de = 1'b0;
        @(negedge clk);
        chk("de_busy", 32'({d_busy, e_busy}), 32'd3);
        chk("e_err_mid_load", 32'(e_sum_err), 32'd0);
        wait_de_done();
        chk("d_done_err", 32'({d_done, d_sum_err}), 32'({1'b1, 1'b0}));
        chk("e_done_err", 32'({e_done, e_sum_err}), 32'({1'b1, 1'b1}));
        start_de = 1'b1;
        @(negedge clk);
        start_de = 1'b0;
        chk("e_err_cleared_by_start", 32'(e_sum_err), 32'd0);
        wait_de_done();
        chk("e_err_second_load", 32'({e_done, e_sum_err}), 32'({1'b1, 1'b1}));
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        a_zero_chk("a_reset");
        chk("b_reset", 32'({b_busy, b_done, b_wr_valid, b_rom_en}), 32'd0);
        chk("c_reset", 32'({c_busy, c_done, c_wr_valid, c_rom_en}), 32'd0);
        fork
            test_a();
            test_b();
            test_c();
`ifdef PARAM_LOADER_CHECKSUM_EN
            test_sum();
`endif
        join
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
